alu8_multibyte_seq: RTL

- Multi-byte operation sequencer that sits directly upstream and downstream of the 8-bit ALU (ALU8Bit).
- Accepts one NBYTES-wide operation per valid/ready handshake and feeds the ALU byte-serially, LSB first, chaining carry between bytes.
- Captures each F byte into a result register and presents the full result, carry and zero flag on an output valid/ready handshake.
- The ALU itself stays external; this block drives its inputs and consumes its outputs.

---
 rtl/alu8_pkg.sv | 32 +++
 rtl/alu8_multibyte_seq_if.sv | 55 +++++
 rtl/alu8_multibyte_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu8_pkg.sv
// Shared definitions for the multi-byte ALU8 sequencer: op codes, FSM states,
// byte width and the signed-overflow rule applied to the final byte.
package alu8_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] OP_SUB_NOTB = 2'b00;
    localparam logic [1:0] OP_NOT_A    = 2'b01;
    localparam logic [1:0] OP_INC      = 2'b10;
    localparam logic [1:0] OP_ADD      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Overflow is judged on the user's op, not the op issued to the ALU for the top byte.
    function automatic logic ovf_flag(input logic [1:0] op, input logic a7,
                                      input logic b7, input logic f7);
        logic v;
        v = 1'b0;
        case (op)
            OP_ADD:      v = (a7 == b7) && (f7 != a7);
            OP_SUB_NOTB: v = (a7 != b7) && (f7 != a7);
            OP_INC:      v = !a7 && f7;
            default:     v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu8_multibyte_seq_if.sv
// Bus bundle for alu8_multibyte_seq. Optional OutOverflow exists only when
// ALU8_OVERFLOW_FLAG_EN is defined.
interface alu8_multibyte_seq_if
    import alu8_pkg::*;
#(
    parameter int NBYTES = 4
);
    // Both In* and Out* are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; ready never depends combinationally on valid.
    logic                    InValid;
    logic                    InReady;
    logic [1:0]              InOp;
    logic [8*NBYTES-1:0]     InA;
    logic [8*NBYTES-1:0]     InB;
    logic                    InCarry;

    logic                    AluS1;
    logic                    AluS0;
    logic [7:0]              AluA;
    logic [7:0]              AluB;
    logic                    AluCarryIn;
    logic [7:0]              AluF;
    logic                    AluCarryOut;

    logic                    OutValid;
    logic                    OutReady;
    logic [8*NBYTES-1:0]     OutF;
    logic                    OutCarry;
    logic                    OutZero;
`ifdef ALU8_OVERFLOW_FLAG_EN
    logic                    OutOverflow;
`endif
    state_e                  dbg_state;

    modport slave (
        input  InValid, InOp, InA, InB, InCarry, AluF, AluCarryOut, OutReady,
        output InReady, AluS1, AluS0, AluA, AluB, AluCarryIn,
        output OutValid, OutF, OutCarry, OutZero,
`ifdef ALU8_OVERFLOW_FLAG_EN
        output OutOverflow,
`endif
        output dbg_state
    );

    modport master (
        output InValid, InOp, InA, InB, InCarry, AluF, AluCarryOut, OutReady,
        input  InReady, AluS1, AluS0, AluA, AluB, AluCarryIn,
        input  OutValid, OutF, OutCarry, OutZero,
`ifdef ALU8_OVERFLOW_FLAG_EN
        input  OutOverflow,
`endif
        input  dbg_state
    );

endinterface

// File: rtl/alu8_multibyte_seq.sv
// Byte-serial sequencer around an external 8-bit ALU: LSB-first, carry chained.
// Optional signed-overflow output enabled by ALU8_OVERFLOW_FLAG_EN.
module alu8_multibyte_seq
    import alu8_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input logic Clock,
    input logic Reset,
    alu8_multibyte_seq_if.slave bus
);

    localparam int KW = $clog2(NBYTES);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d, k_nxt;
    logic [1:0]          op_q, op_d;
    word_t               a_q, a_d;
    word_t               b_q, b_d;
    word_t               res_q, res_d;
    logic                out_valid_q, out_valid_d;
    logic                out_carry_q, out_carry_d;
    logic                out_zero_q, out_zero_d;
    logic [1:0]          alu_s_q, alu_s_d;
    logic [BYTE_W-1:0]   alu_a_q, alu_a_d;
    logic [BYTE_W-1:0]   alu_b_q, alu_b_d;
    logic                alu_cin_q, alu_cin_d;
    logic                accept;
`ifdef ALU8_OVERFLOW_FLAG_EN
    logic                out_ovf_q, out_ovf_d;
`endif

    assign bus.InReady = (state_q == ST_IDLE) & ~Reset;
    assign accept      = bus.InValid & bus.InReady;
    assign k_nxt       = k_q + KW'(1);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_carry_d = out_carry_q;
        out_zero_d  = out_zero_q;
        alu_s_d     = alu_s_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
`ifdef ALU8_OVERFLOW_FLAG_EN
        out_ovf_d   = out_ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_RUN;
                    op_d      = bus.InOp;
                    a_d       = bus.InA;
                    b_d       = bus.InB;
                    k_d       = '0;
                    alu_s_d   = bus.InOp;
                    alu_a_d   = bus.InA[BYTE_W-1:0];
                    alu_b_d   = bus.InB[BYTE_W-1:0];
                    alu_cin_d = (bus.InOp == OP_ADD || bus.InOp == OP_SUB_NOTB)
                                ? bus.InCarry : 1'b0;
                end
            end
            ST_RUN: begin
                res_d[k_q] = bus.AluF;
                if (k_q == K_LAST) begin
                    state_d     = ST_DONE;
                    k_d         = '0;
                    out_valid_d = 1'b1;
                    out_carry_d = (op_q == OP_NOT_A) ? 1'b0 : bus.AluCarryOut;
                    out_zero_d  = (res_d == '0);
                    alu_s_d     = 2'b00;
                    alu_a_d     = '0;
                    alu_b_d     = '0;
                    alu_cin_d   = 1'b0;
`ifdef ALU8_OVERFLOW_FLAG_EN
                    out_ovf_d   = ovf_flag(op_q, a_q[K_LAST][BYTE_W-1],
                                           b_q[K_LAST][BYTE_W-1], bus.AluF[BYTE_W-1]);
`endif
                end else begin
                    k_d     = k_nxt;
                    alu_a_d = a_q[k_nxt];
                    case (op_q)
                        // Upper bytes of an increment are an add of zero plus the
                        // chained carry, so the ALU's forced carry hits byte 0 only.
                        OP_INC: begin
                            alu_s_d   = OP_ADD;
                            alu_b_d   = '0;
                            alu_cin_d = bus.AluCarryOut;
                        end
                        OP_NOT_A: begin
                            alu_s_d   = OP_NOT_A;
                            alu_b_d   = b_q[k_nxt];
                            alu_cin_d = 1'b0;
                        end
                        default: begin
                            alu_s_d   = op_q;
                            alu_b_d   = b_q[k_nxt];
                            alu_cin_d = bus.AluCarryOut;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                if (bus.OutReady) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_carry_q <= 1'b0;
            out_zero_q  <= 1'b0;
            alu_s_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
`ifdef ALU8_OVERFLOW_FLAG_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_carry_q <= out_carry_d;
            out_zero_q  <= out_zero_d;
            alu_s_q     <= alu_s_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
`ifdef ALU8_OVERFLOW_FLAG_EN
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign {bus.AluS1, bus.AluS0} = alu_s_q;
    assign bus.AluA        = alu_a_q;
    assign bus.AluB        = alu_b_q;
    assign bus.AluCarryIn  = alu_cin_q;
    assign bus.OutValid    = out_valid_q;
    assign bus.OutF        = res_q;
    assign bus.OutCarry    = out_carry_q;
    assign bus.OutZero     = out_zero_q;
`ifdef ALU8_OVERFLOW_FLAG_EN
    assign bus.OutOverflow = out_ovf_q;
`endif
    assign bus.dbg_state   = state_q;

endmodule
